// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3
// codes and the registered control bundle carried from MEM into WB.
package wb_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PC4  = 2'b10,
    RS_RSVD = 2'b11
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    result_src_t result_src;
    logic [2:0]  funct3;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load-data extraction and sign/zero extension; purely combinational, zero latency.
// No flow control: output follows inputs.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword alignment only looks at the upper offset bit.
    half_sel = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register, result select, register-file write port and retired count.
// Writes commit one edge after capture; stall holds all state and blocks the write.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [1:0]      mem_result_src,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_read_data,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic            stall,
  input  logic            flush,
  output logic [RA_W-1:0] rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic [31:0]     rf_we3,
  output logic            wb_valid,
  output logic            wb_fwd_en,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic [63:0]     instret
);

  wb_ctrl_t        ctrl;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] result;
  logic            writes_reg;
  logic            we;

  // Data fields are captured even on flush; the cleared valid bit suppresses them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
    end else if (!stall) begin
      ctrl.valid      <= mem_valid & ~flush;
      ctrl.reg_write  <= mem_reg_write;
      ctrl.result_src <= result_src_t'(mem_result_src);
      ctrl.funct3     <= mem_funct3;
      rd_q            <= mem_rd;
      alu_q           <= mem_alu_result;
      rdata_q         <= mem_read_data;
      pc4_q           <= mem_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (ctrl.valid && !stall) begin
      instret <= instret + 64'd1;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .funct3 (ctrl.funct3),
    .offset (alu_q[1:0]),
    .word   (rdata_q),
    .ext    (load_val)
  );

  always_comb begin
    case (ctrl.result_src)
      RS_LOAD: result = load_val;
      RS_PC4:  result = pc4_q;
      default: result = alu_q;
    endcase
  end

  assign writes_reg = ctrl.valid & ctrl.reg_write & (rd_q != '0);
  assign we         = writes_reg & ~stall;

  assign rf_a3     = rd_q;
  assign rf_wd3    = result;
  assign rf_we3    = {31'b0, we};
  assign wb_valid  = ctrl.valid;
  assign wb_fwd_en = writes_reg;
  assign wb_rd     = rd_q;
  assign wb_result = result;

endmodule
